tx_byte_queue: RTL

- Byte FIFO plus drain controller between the keyboard/switch send logic and the UART transmitter.
- Accepts single-cycle byte writes (keyboard ASCII with language bit, or switch value) at any rate.
- Issues one tx_start pulse per byte to the UART only when the transmitter is idle, so bytes written while tx_busy is high are no longer lost.

---
 rtl/tx_byte_queue.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/tx_byte_queue.sv
// tx_byte_queue: byte FIFO plus drain controller feeding a UART transmitter.
//
// Bytes from the keyboard/switch send logic are written with single-cycle
// strobes at any rate. The drain controller pops one byte at a time. It
// pops only while the UART is idle, so a byte written during a transmission
// waits in the queue instead of being lost.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   wr_data  in   byte to enqueue
//   wr_en    in   one-cycle write strobe
//   flush    in   synchronous clear of all queued bytes
//   full     out  queue holds 2**ADDR_W bytes
//   empty    out  queue holds no bytes
//   count    out  queued bytes, excluding the byte in flight
//   drop     out  one-cycle pulse: previous-cycle write rejected (queue full)
//   tx_data  out  byte presented to the UART, held from start to next pop
//   tx_start out  one-cycle start pulse to the UART
//   tx_busy  in   UART transmitter busy

module tx_byte_queue #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned BUSY_WAIT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_en,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              drop,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_start,
   input  logic              tx_busy
);

   localparam int unsigned Depth = 2 ** ADDR_W;
   localparam int unsigned CntW  = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
   localparam logic [CntW-1:0] WaitLast = CntW'(BUSY_WAIT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StWaitBusy,
      StWaitDone
   } state_e;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [Depth];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              drop_q, drop_d;

   state_e            state_q, state_d;
   logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              tx_start_q, tx_start_d;

   logic full_w;
   logic empty_w;
   logic pop;
   logic push;

   // ------------------------------------------------------------------
   // Queue status and handshake
   // ------------------------------------------------------------------
   assign full_w  = (count_q == (ADDR_W + 1)'(Depth));
   assign empty_w = (count_q == '0);

   // Pop is judged on registered count only, so a byte written into an
   // empty queue is popped one edge later (no write-to-read bypass).
   assign pop  = (state_q == StIdle) && !empty_w && !tx_busy;

   // A pop in the same cycle frees the slot the write needs. Flush wins
   // over any write and suppresses the drop pulse.
   assign push = wr_en && !flush && (!full_w || pop);

   // ------------------------------------------------------------------
   // Pointer / count next state
   // ------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = wr_en && !flush && full_w && !pop;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Drain controller next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (pop) begin
               tx_data_d  = mem_q[rd_ptr_q];
               tx_start_d = 1'b1;
               state_d    = StStart;
            end
         end
         StStart: begin
            wait_cnt_d = '0;
            state_d    = StWaitBusy;
         end
         StWaitBusy: begin
            // A UART that never raises busy still releases the controller
            // after BUSY_WAIT cycles; the byte is treated as sent.
            if (tx_busy) begin
               state_d = StWaitDone;
            end else if (wait_cnt_q == WaitLast) begin
               state_d = StIdle;
            end else begin
               wait_cnt_d = wait_cnt_q + CntW'(1);
            end
         end
         StWaitDone: begin
            if (!tx_busy) begin
               state_d = StIdle;
            end
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   // Controller state and its registered outputs; flush does not touch it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign full     = full_w;
   assign empty    = empty_w;
   assign count    = count_q;
   assign drop     = drop_q;
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;

   // ------------------------------------------------------------------
   // Internal consistency
   // ------------------------------------------------------------------
   a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= (ADDR_W + 1)'(Depth));

   a_start_in_start: assert property (@(posedge clk) disable iff (!rst_n)
      tx_start_q == (state_q == StStart));

endmodule
